// File: rtl/pvt_measure_sequencer_if.sv
// pvt_measure_sequencer_if: start/done/data handshake between the sequencer (master) and the PVT monitors (slave).
interface pvt_measure_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 8
);
    logic [NUM_CH-1:0] mon_start;
    logic [NUM_CH-1:0] mon_done;
    logic [NUM_CH*CNT_W-1:0] mon_data;
    modport master (output mon_start, input mon_done, input mon_data);
    modport slave (input mon_start, output mon_done, output mon_data);
endinterface

// File: rtl/pvt_measure_sequencer.sv
// pvt_measure_sequencer: sweeps masked PVT monitor channels one at a time, capturing result or timeout per channel.
// Defining PVT_SEQ_MINMAX_EN adds rd_min/rd_max per-channel extremes readout.
module pvt_measure_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic single,
    input  logic clr,
    input  logic [NUM_CH-1:0] ch_mask,
    pvt_measure_sequencer_if.master mon,
    input  logic [$clog2(NUM_CH)-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
`ifdef PVT_SEQ_MINMAX_EN
    output logic [CNT_W-1:0] rd_min,
    output logic [CNT_W-1:0] rd_max,
`endif
    output logic busy,
    output logic sweep_done,
    output logic [NUM_CH-1:0] timeout_flags,
    output logic [7:0] sweep_cnt
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_t;
    state_t state;
    logic [CH_W-1:0] ch, first_ch, next_ch;
    logic has_next, cap_done, cap_to, rd_ok;
    logic [NUM_CH-1:0] mask_q;
    logic [TW-1:0] timer;
    logic [CNT_W-1:0] result [NUM_CH];
    logic [CNT_W-1:0] cap_data;
    always_comb begin
        first_ch = '0;
        next_ch = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = CH_W'(i);
            if (mask_q[i] && i > int'(ch)) begin
                next_ch = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end
    assign cap_data = mon.mon_data[int'(ch)*CNT_W +: CNT_W];
    assign cap_done = state == WAIT && mon.mon_done[ch];
    assign cap_to = state == WAIT && !mon.mon_done[ch] && timer == TW'(TIMEOUT);
    assign rd_ok = int'(rd_sel) < NUM_CH;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch <= '0;
            mask_q <= '0;
            timer <= '0;
            mon.mon_start <= '0;
            busy <= 1'b0;
            sweep_done <= 1'b0;
            sweep_cnt <= '0;
            timeout_flags <= '0;
            rd_data <= '0;
            for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
        end else begin
            mon.mon_start <= '0;
            sweep_done <= 1'b0;
            if (clr) begin
                for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
                timeout_flags <= '0;
                sweep_cnt <= '0;
            end
            case (state)
                IDLE: if ((run || single) && |ch_mask) begin
                    mask_q <= ch_mask;
                    ch <= first_ch;
                    mon.mon_start <= NUM_CH'(1) << first_ch;
                    busy <= 1'b1;
                    state <= START;
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // capture after the clear above so a same-cycle capture survives clr
                    if (cap_done || cap_to) begin
                        result[ch] <= cap_done ? cap_data : '1;
                        timeout_flags[ch] <= cap_to;
                        state <= NEXT;
                    end
                end
                NEXT: if (has_next) begin
                    ch <= next_ch;
                    mon.mon_start <= NUM_CH'(1) << next_ch;
                    state <= START;
                end else begin
                    sweep_cnt <= (clr ? 8'd0 : sweep_cnt) + 8'd1;
                    sweep_done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            rd_data <= rd_ok ? result[rd_sel] : '0;
        end
    end
`ifdef PVT_SEQ_MINMAX_EN
    logic [CNT_W-1:0] mn [NUM_CH];
    logic [CNT_W-1:0] mx [NUM_CH];
    logic [NUM_CH-1:0] vld;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mn[i] <= '1;
                mx[i] <= '0;
            end
            vld <= '0;
            rd_min <= '0;
            rd_max <= '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    mn[i] <= '1;
                    mx[i] <= '0;
                end
                vld <= '0;
            end
            if (cap_done) begin
                mn[ch] <= (!vld[ch] || clr || cap_data < mn[ch]) ? cap_data : mn[ch];
                mx[ch] <= (!vld[ch] || clr || cap_data > mx[ch]) ? cap_data : mx[ch];
                vld[ch] <= 1'b1;
            end
            rd_min <= (rd_ok && vld[rd_sel]) ? mn[rd_sel] : '0;
            rd_max <= (rd_ok && vld[rd_sel]) ? mx[rd_sel] : '0;
        end
    end
`endif
endmodule

// File: doc/pvt_measure_sequencer.md
# pvt_measure_sequencer

Measurement sequencer for the PVT monitor suite. It sweeps a mask of monitor channels (ring-oscillator counters, clk-to-q/setup measurers, skew detectors) and runs one channel at a time. For each channel it issues a single-cycle start pulse, waits for done or a timeout, and captures the result byte into a per-channel register. Results, timeout flags and a sweep counter can be read back through a byte-select port that drives the shared `uio_out` readout mux.

## Interface
Parameters:
- `NUM_CH`, default 4: number of monitor channels (2..8).
- `CNT_W`, default 8: result width per channel.
- `TIMEOUT`, default 1023: maximum WAIT cycles minus one; timer width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level input; sweeps repeat while it is high.
- `single`, in, 1: a one-cycle pulse in IDLE requests exactly one sweep.
- `clr`, in, 1: synchronous clear of results, timeout flags and sweep counter.
- `ch_mask`, in, NUM_CH: enabled channels; sampled only at sweep start.
- `mon_done`, in, NUM_CH: per-channel done pulse, already synchronous to `clk`.
- `mon_data`, in, NUM_CH*CNT_W: packed results; channel i occupies `[i*CNT_W +: CNT_W]`.
- `rd_sel`, in, `$clog2(NUM_CH)`: readout channel select.
- `mon_start`, out, NUM_CH: one-hot start pulse.
- `rd_data`, out, CNT_W: registered result of channel `rd_sel`.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `sweep_done`, out, 1: one-cycle pulse at sweep completion.
- `timeout_flags`, out, NUM_CH: sticky per-channel timeout status.
- `sweep_cnt`, out, 8: number of completed sweeps, wraps modulo 256.

## Operation
FSM states: IDLE, START, WAIT, NEXT.
- **IDLE**
  - If (`run` | `single`) and `ch_mask` != 0: latch `mask_q` = `ch_mask`, set `ch` = lowest set bit, go to START.
  - If `ch_mask` == 0: remain in IDLE and drop `single`.
- **START**
  - Drive `mon_start[ch]` = 1 for exactly this cycle.
  - Clear the timer and go to WAIT.
- **WAIT**
  - The timer increments every cycle.
  - If `mon_done[ch]`: `result[ch]` <= `mon_data[ch]`, clear `timeout_flags[ch]`, go to NEXT.
  - Else if timer == TIMEOUT: set `timeout_flags[ch]`, `result[ch]` <= all ones, go to NEXT.
  - Done on the same cycle the timer reaches TIMEOUT takes priority over the timeout.
- **NEXT**
  - If `mask_q` has a set bit above `ch`: `ch` = that bit, go to START.
  - Otherwise: `sweep_cnt` += 1 (8-bit wrap), assert `sweep_done` on the following cycle, go to IDLE.
- `mon_done` on non-selected channels, or while in IDLE, START or NEXT, is ignored.
- `run` falling mid-sweep: the current sweep completes; no new sweep starts.
- `single` while busy is ignored. `single` held together with `run` is equivalent to `run`.
- `clr` zeroes `result[*]`, `timeout_flags` and `sweep_cnt` in the next cycle.
  - It does not disturb the FSM.
  - A capture in the same cycle wins for its channel.
- `rd_data` <= `result[rd_sel]`; an out-of-range `rd_sel` gives 0.
- Reset values: all outputs 0, state IDLE, `result[*]` 0, `mask_q` 0.
- Asserting `rst_n` low mid-sweep immediately deasserts `mon_start` and `busy`. No partial result is kept.

## Timing
- IDLE to first `mon_start`: 1 cycle after `run`/`single` is sampled.
- Per channel: START (1 cycle) + WAIT (k+1 cycles, where done arrives in WAIT cycle k) + NEXT (1 cycle).
  - Worst case is TIMEOUT+3 cycles.
- `busy` rises in the START cycle and falls in the cycle `sweep_done` is high.
- When `sweep_done` is high, results, flags and `sweep_cnt` are already updated.
- Between back-to-back `run` sweeps there is one IDLE cycle, in which `sweep_done` is high.
- `rd_data` has 1-cycle latency from `rd_sel`, or from a result update.

## Configuration
- `PVT_SEQ_MINMAX_EN` defined:
  - Adds outputs `rd_min`/`rd_max` (CNT_W each, registered, same latency as `rd_data`).
  - These track the per-channel minimum and maximum of captured non-timeout results since reset or `clr`.
  - Both read 0 until the first capture. `clr` resets min to all ones and max to 0, and marks the channel empty again.
- Undefined: the min/max ports and registers are absent; all other behaviour is identical.

## Test plan
Bench parameters: NUM_CH=4, CNT_W=8, TIMEOUT=15.
- **Reset:** hold `rst_n`=0 with `run`=1.
  - All outputs 0.
  - After release, the first `mon_start` appears 1 cycle after `run` is sampled.
- **Single sweep:** `single` with `ch_mask`=4'b0101; the model returns done 3 cycles after start with data 0x5A (ch0) and 0xA5 (ch2).
  - `mon_start` shows 0001 then 0100.
  - `rd_data` reads 0x5A, 0x00, 0xA5, 0x00 for `rd_sel`=0..3.
  - `sweep_cnt`=1, with one `sweep_done` pulse.
- **Timeout:** `ch_mask`=4'b0010, no done.
  - Exactly 16 WAIT cycles.
  - `timeout_flags`=0010 and `rd_sel`=1 reads 0xFF.
  - A later sweep with done clears the flag.
- **Run and wrap:** `run` held with mask 1111 and immediate done.
  - `sweep_cnt` wraps from 255 to 0 after 256 sweeps.
  - Dropping `run` mid-sweep completes ch3 and then idles.
- **Corner events:**
  - Done on a non-selected channel: ignored.
  - Done on timer==15: captured, no flag set.
  - `single` while busy: ignored.
  - `clr` during WAIT: the sweep still finishes.
  - Async reset mid-WAIT: `busy`=0 at once.
- **MINMAX (macro on):** captures 0x40, 0x10, 0x80 on ch1.
  - `rd_min`=0x10, `rd_max`=0x80.
  - A timeout leaves both unchanged.
